// File: rtl/aoc_host_link.sv
`default_nettype none
// ============================================================================
//  Module   : aoc_host_link
//  Purpose  : Host-side initiator for the puzzle-solver UART link. Frames a
//             job (4-byte header + packed BCD line data), sends it over an
//             8E2 UART, then collects the 8-byte big-endian result.
//  Revision : 1.0  initial release
// ============================================================================
module aoc_host_link #(
   parameter int CLK_FREQ     = 12_000_000,
   parameter int BAUD_RATE    = 921_600,
   parameter int LINE_GAP     = 64,
   parameter int RESP_TIMEOUT = 2_000_000
) (
   input  logic        sysclk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  cfg_len,
   input  logic [11:0] cfg_lines,
   input  logic [3:0]  cfg_digits,
   input  logic [7:0]  s_data,
   input  logic        s_valid,
   output logic        s_ready,
   output logic        uart_tx,
   input  logic        uart_rx,
   output logic        busy,
   output logic [63:0] result,
   output logic        result_valid,
   output logic        parity_err,
   output logic        timeout
);

   localparam logic [31:0] CPB      = 32'(CLK_FREQ / BAUD_RATE);
   localparam logic [31:0] HALF     = CPB / 32'd2;
   localparam logic [31:0] GAP_LAST = 32'(LINE_GAP - 1);
   localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, HDR, DATA, GAP, RESP, DONE} state_t;

   state_t      state;
   logic [7:0]  len_q;
   logic [11:0] lines_q;
   logic [3:0]  digits_q;
   logic [2:0]  hdr_idx;
   logic [7:0]  byte_cnt;
   logic [11:0] line_cnt;
   logic [31:0] gap_cnt;
   logic [31:0] resp_cnt;
   logic [3:0]  rx_cnt;
   logic [63:0] acc;

   // transmitter
   logic        tx_busy;
   logic [31:0] tx_cyc;
   logic [3:0]  tx_bit;
   logic [10:0] tx_frame;
   logic        tx_go;
   logic        tx_done;
   logic [7:0]  tx_byte;
   logic [7:0]  hdr_byte;

   // receiver
   logic        rx_meta;
   logic        rx_sync;
   logic        rx_active;
   logic [31:0] rx_cyc;
   logic [3:0]  rx_bit;
   logic [8:0]  rx_sh;
   logic        rx_done;
   logic [7:0]  rx_data;
   logic        rx_perr;

   // Header byte selected by position within the 4-byte header
   always_comb begin
      case (hdr_idx)
         3'd0:    hdr_byte = 8'hAA;
         3'd1:    hdr_byte = len_q;
         3'd2:    hdr_byte = lines_q[11:4];
         default: hdr_byte = {lines_q[3:0], digits_q};
      endcase
   end

   // Source accepts only when nothing is in flight, so one byte at most is queued
   assign s_ready = (state == DATA) && !tx_busy && (byte_cnt != len_q);
   // Last cycle of the second stop bit
   assign tx_done = tx_busy && (tx_cyc == CPB - 32'd1) && (tx_bit == 4'd11);

   // Choose what (if anything) to hand to the transmitter this cycle
   always_comb begin
      tx_go   = 1'b0;
      tx_byte = hdr_byte;
      if (state == HDR && !tx_busy && !hdr_idx[2]) begin
         tx_go = 1'b1;
      end else if (s_ready && s_valid) begin
         tx_go   = 1'b1;
         tx_byte = s_data;
      end
   end

   // 8E2 transmitter: start, 8 data LSB first, even parity, two stops
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         uart_tx  <= 1'b1;
         tx_busy  <= 1'b0;
         tx_cyc   <= '0;
         tx_bit   <= '0;
         tx_frame <= '0;
      end else if (tx_go) begin
         uart_tx  <= 1'b0;
         tx_busy  <= 1'b1;
         tx_cyc   <= '0;
         tx_bit   <= '0;
         tx_frame <= {2'b11, ^tx_byte, tx_byte};
      end else if (tx_busy) begin
         if (tx_cyc == CPB - 32'd1) begin
            tx_cyc <= '0;
            if (tx_bit == 4'd11) begin
               tx_busy <= 1'b0;
               uart_tx <= 1'b1;
            end else begin
               tx_bit   <= tx_bit + 4'd1;
               uart_tx  <= tx_frame[0];
               tx_frame <= {1'b1, tx_frame[10:1]};
            end
         end else begin
            tx_cyc <= tx_cyc + 32'd1;
         end
      end
   end

   // Receiver: double-flop the line, sample each bit mid-way, check parity and stop
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_active <= 1'b0;
         rx_cyc    <= '0;
         rx_bit    <= '0;
         rx_sh     <= '0;
         rx_done   <= 1'b0;
         rx_data   <= '0;
         rx_perr   <= 1'b0;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_done <= 1'b0;
         if (!rx_active) begin
            if (!rx_sync) begin
               rx_active <= 1'b1;
               rx_cyc    <= '0;
               rx_bit    <= '0;
            end
         end else begin
            if (rx_cyc == HALF) begin
               case (rx_bit)
                  4'd0: if (rx_sync) rx_active <= 1'b0;
                  4'd10: begin
                     rx_active <= 1'b0;
                     if (rx_sync) begin
                        rx_done <= 1'b1;
                        rx_data <= rx_sh[7:0];
                        rx_perr <= (^rx_sh[7:0]) != rx_sh[8];
                     end
                  end
                  default: rx_sh <= {rx_sync, rx_sh[8:1]};
               endcase
            end
            if (rx_cyc == CPB - 32'd1) begin
               rx_cyc <= '0;
               rx_bit <= rx_bit + 4'd1;
            end else begin
               rx_cyc <= rx_cyc + 32'd1;
            end
         end
      end
   end

   // Job sequencer: header, lines with gaps, then response collection
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         len_q        <= '0;
         lines_q      <= '0;
         digits_q     <= '0;
         hdr_idx      <= '0;
         byte_cnt     <= '0;
         line_cnt     <= '0;
         gap_cnt      <= '0;
         resp_cnt     <= '0;
         rx_cnt       <= '0;
         acc          <= '0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         parity_err   <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start && cfg_len != 8'd0) begin
                  len_q      <= cfg_len;
                  lines_q    <= cfg_lines;
                  digits_q   <= cfg_digits;
                  parity_err <= 1'b0;
                  timeout    <= 1'b0;
                  busy       <= 1'b1;
                  hdr_idx    <= '0;
                  state      <= HDR;
               end
            end
            HDR: begin
               if (tx_go) begin
                  hdr_idx <= hdr_idx + 3'd1;
               end else if (hdr_idx[2] && tx_done) begin
                  if (lines_q == 12'd0) begin
                     resp_cnt <= '0;
                     rx_cnt   <= '0;
                     state    <= RESP;
                  end else begin
                     line_cnt <= lines_q;
                     byte_cnt <= '0;
                     state    <= DATA;
                  end
               end
            end
            DATA: begin
               if (tx_go) begin
                  byte_cnt <= byte_cnt + 8'd1;
               end else if (byte_cnt == len_q && tx_done) begin
                  line_cnt <= line_cnt - 12'd1;
                  byte_cnt <= '0;
                  gap_cnt  <= '0;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  if (line_cnt == 12'd0) begin
                     resp_cnt <= '0;
                     rx_cnt   <= '0;
                     state    <= RESP;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  gap_cnt <= gap_cnt + 32'd1;
               end
            end
            RESP: begin
               resp_cnt <= resp_cnt + 32'd1;
               if (rx_done) begin
                  acc    <= {acc[55:0], rx_data};
                  rx_cnt <= rx_cnt + 4'd1;
                  if (rx_perr) parity_err <= 1'b1;
               end
               if (rx_done && rx_cnt == 4'd7) begin
                  result       <= {acc[55:0], rx_data};
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else if (resp_cnt == TMO_LAST) begin
                  timeout <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/aoc_host_link.md
Name: aoc_host_link

Overview:
- Host-side initiator for the puzzle-solver UART link: frames a job (4-byte header plus packed BCD line data), serialises it on its own 8E2 UART transmitter, then collects the 8-byte big-endian result on its own receiver.
- Sits between an on-board digit source (ROM streamer or loopback test harness) and the solver core's serial pins. This lets the solver be exercised board-to-board or in simulation without a PC.

Parameters:
CLK_FREQ, 12_000_000, sysclk frequency in Hz
BAUD_RATE, 921_600, line rate; CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide)
LINE_GAP, 64, idle cycles inserted after each line so the solver finishes its per-line calculation
RESP_TIMEOUT, 2_000_000, cycles allowed from end of transmission to the 8th result byte

Ports:
sysclk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle job request; sampled only in IDLE
cfg_len  in  8  bytes per line (1..100), i.e. two BCD digits per byte
cfg_lines  in  12  number of lines (0..4095)
cfg_digits  in  4  digits the solver picks per line (1..15)
s_data  in  8  packed digit pair, high nibble is the earlier digit
s_valid  in  1  s_data valid
s_ready  out  1  byte accepted when s_valid & s_ready
uart_tx  out  1  serial out to solver; idle high
uart_rx  in  1  serial in from solver; asynchronous, double-flopped internally
busy  out  1  high from accepted start until DONE is left
result  out  64  received sum, first byte = bits 63:56
result_valid  out  1  one-cycle pulse when result is updated
parity_err  out  1  sticky per job; set on any bad result-byte parity
timeout  out  1  sticky per job; set when RESP_TIMEOUT expires

Behaviour:
- Reset values (asynchronous, all outputs):
  - uart_tx=1; all other outputs 0.
  - FSM in IDLE, all counters 0.
  - Reset asserted mid-frame drives uart_tx high immediately; no partial byte is completed.
- TX frame format:
  - start bit 0, data bits 0..7 LSB first, even-parity bit (^data), two stop bits 1.
  - Each bit is held exactly CYCLES_PER_BIT cycles, so a frame is 12 bit-times.
  - A new frame may begin the cycle after the last stop bit ends.
- RX frame format:
  - Start is detected when the synchronised line is low; each bit is sampled at CYCLES_PER_BIT/2 into the bit.
  - Start bit sampled high: abort the frame, no byte produced.
  - Stop bit sampled 0: byte discarded and byte counter unchanged.
- FSM:
  - IDLE:
    - start & cfg_len!=0 -> latch cfg_*, clear parity_err, clear timeout, set busy, go to HDR.
    - start with cfg_len==0 is ignored.
  - HDR: send 0xAA, cfg_len, cfg_lines[11:4], {cfg_lines[3:0], cfg_digits}.
    - cfg_lines==0 -> RESP.
    - Otherwise -> DATA with line_cnt=cfg_lines, byte_cnt=0.
  - DATA:
    - s_ready=1 only while the transmitter is idle and no byte is held; this gives at most one byte in flight.
    - Each accepted byte is transmitted and increments byte_cnt.
    - After the cfg_len-th byte's stop bits end: line_cnt-1, byte_cnt=0, go to GAP.
  - GAP:
    - Wait LINE_GAP cycles with uart_tx high.
    - Then line_cnt==0 -> RESP, else -> DATA.
  - RESP:
    - s_ready=0. Receive 8 bytes, shifting in MSB-byte first.
    - The timeout counter starts on entry and is not reset by received bytes.
    - 8th byte received -> result updated, result_valid pulse, go to DONE.
    - Counter reaches RESP_TIMEOUT first -> timeout=1, result unchanged, go to DONE.
    - Bytes arriving in any other state are dropped.
  - DONE: busy=0 next cycle, go to IDLE. A start in the same cycle as DONE is ignored.
- s_valid low stalls DATA indefinitely. There is no underflow error and uart_tx stays idle.
- cfg_* changes during busy have no effect.

Test Plan:
- Header framing: cfg_len=0x32, cfg_lines=0x0C8, cfg_digits=0xC, start -> bytes AA 32 0C 8C on uart_tx. Each frame is 12 bit-times of 13 cycles (12 MHz / 921600 = 13), with the correct parity bit.
- Full job: 2 lines × 2 bytes (0x98, 0x76 then 0x11, 0x19), digits=2, loopback responder replies 00 00 00 00 00 00 00 B3.
  - Line gaps are ≥64 cycles.
  - result=0x00000000000000B3 with a single result_valid pulse.
  - busy drops one cycle after the pulse.
- Stalled source: s_valid low for 500 cycles mid-line -> uart_tx high throughout, s_ready high. Transmission resumes on the next valid byte with no duplicated or lost byte.
- Zero lines: cfg_lines=0 -> header only, then RESP.
  - 8 reply bytes with a wrong parity bit on byte 3 -> result_valid pulses and parity_err=1.
  - parity_err clears on the next start.
- Timeout: no reply with RESP_TIMEOUT=1000 -> timeout=1 exactly 1000 cycles after RESP entry, result unchanged, busy falls.
- Reset mid-frame: rst_n low during data bit 4 -> uart_tx=1, busy=0 and s_ready=0 immediately. After release, start with cfg_len=0 is ignored.
